// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared constants for the registered ALU control decoder.
//   - ALUOp encodings from the main control unit
//   - funct field codes recognised under ALUOp=10
//   - 4-bit ALU control codes driven to the ALU
//   - mult/div operation encoding presented to the HI/LO unit
//   - state type and state constants of the mult/div sequencer FSM
package alu_ctrl_pkg;

  // ALUOp from main control
  localparam logic [1:0] ALUOP_MEM = 2'b00;  // lw/sw address add
  localparam logic [1:0] ALUOP_BR  = 2'b01;  // beq compare subtract
  localparam logic [1:0] ALUOP_R   = 2'b10;  // R-type, decode funct
  localparam logic [1:0] ALUOP_ORI = 2'b11;  // ori

  // funct field codes
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  // ALU control codes
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  // HI/LO read select
  localparam logic [1:0] HILO_NONE = 2'b00;
  localparam logic [1:0] HILO_HI   = 2'b01;
  localparam logic [1:0] HILO_LO   = 2'b10;

  // mult/div operation encoding; equals funct[1:0] of the four md opcodes
  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  // mult/div sequencer FSM
  typedef logic [0:0] md_state_t;
  localparam md_state_t MD_IDLE = 1'b0;
  localparam md_state_t MD_RUN  = 1'b1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alu_ctrl_seq_md_seq.sv
// md_seq: IDLE/RUN sequencer for multi-cycle mult/div operations.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : issue a mult/div this edge (only asserted while idle)
//   is_div     : the issued op is div/divu (selects DIV_CYCLES latency)
//   op         : md operation encoding to latch and hold
//   md_op      : latched operation, held while busy and afterwards
//   busy       : operation in flight (state RUN)
//   hilo_we    : one-cycle HI/LO write strobe in the last RUN cycle
//   state      : FSM state, exposed for debug
module md_seq
  import alu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      start,
  input  logic      is_div,
  input  logic [1:0] op,
  output logic [1:0] md_op,
  output logic      busy,
  output logic      hilo_we,
  output md_state_t state
);

  localparam int MAX_CYC = max_int(MULT_CYCLES, DIV_CYCLES);
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  // The counter is loaded with latency-1 and the strobe fires when it
  // reaches zero, so the op occupies exactly <latency> RUN cycles.
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MD_IDLE;
      cnt   <= '0;
      md_op <= MD_MULT;
    end else begin
      if (start) begin
        state <= MD_RUN;
        cnt   <= is_div ? DIV_LOAD : MULT_LOAD;
        md_op <= op;
      end else if (state == MD_RUN) begin
        if (cnt == '0) begin
          state <= MD_IDLE;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

  assign busy    = (state == MD_RUN);
  assign hilo_we = busy && (cnt == '0);

endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered MIPS32 ALU control decoder with mult/div
// sequencing for the multi-cycle datapath.
// Optional feature macro: ALU_CTRL_DIV_EN (defined -> div/divu are
// sequenced; undefined -> div/divu are flagged illegal).
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   valid_i      : instruction present this cycle
//   funct_i      : funct field
//   alu_op_i     : ALUOp from main control
//   alu_ctl_o    : registered ALU control code (holds when nothing accepted)
//   ctl_valid_o  : alu_ctl_o / illegal_o / hilo_sel_o refer to an accepted op
//   illegal_o    : unsupported funct under ALUOp=10
//   hilo_sel_o   : 01 mfhi, 10 mflo, 00 none
//   md_start_o   : one-cycle pulse when a mult/div is issued
//   md_op_o      : 00 mult, 01 multu, 10 div, 11 divu; held while busy
//   busy_o       : multi-cycle op in flight
//   hilo_we_o    : one-cycle HI/LO write strobe at completion
//   stall_o      : combinational; the presented instruction is not accepted
//   md_state_o   : mult/div sequencer FSM state (debug)
//
// Handshake: an instruction transfers on a rising edge where valid_i=1 and
// stall_o=0 (stall_o acts as an inverted ready). stall_o never depends on
// anything registered in this cycle by the same transfer, and a stalled
// instruction must be held by the producer until it is accepted.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int SIZEOP      = 6,
  parameter int SIZE_ALU_OP = 2,
  parameter int S_ALU       = 4,
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid_i,
  input  logic [SIZEOP-1:0]      funct_i,
  input  logic [SIZE_ALU_OP-1:0] alu_op_i,
  output logic [S_ALU-1:0]       alu_ctl_o,
  output logic                   ctl_valid_o,
  output logic                   illegal_o,
  output logic [1:0]             hilo_sel_o,
  output logic                   md_start_o,
  output logic [1:0]             md_op_o,
  output logic                   busy_o,
  output logic                   hilo_we_o,
  output logic                   stall_o,
  output md_state_t              md_state_o
);

  logic [5:0] f6;
  logic [1:0] op2;
  logic [3:0] dec_code;
  logic       dec_ill;
  logic [1:0] dec_hsel;
  logic       dec_md;      // op starts the mult/div sequencer
  logic       dec_hazard;  // op touches HI/LO and must wait for the sequencer
  logic       accept;
  logic       md_go;

  assign f6  = 6'(funct_i);
  assign op2 = 2'(alu_op_i);

  always_comb begin
    dec_code   = ALU_ADD;
    dec_ill    = 1'b0;
    dec_hsel   = HILO_NONE;
    dec_md     = 1'b0;
    dec_hazard = 1'b0;
    case (op2)
      ALUOP_MEM: dec_code = ALU_ADD;
      ALUOP_BR:  dec_code = ALU_SUB;
      ALUOP_ORI: dec_code = ALU_OR;
      default: begin
        case (f6)
          F_ADD, F_ADDU: dec_code = ALU_ADD;
          F_SUB, F_SUBU: dec_code = ALU_SUB;
          F_AND:         dec_code = ALU_AND;
          F_OR:          dec_code = ALU_OR;
          F_XOR:         dec_code = ALU_XOR;
          F_NOR:         dec_code = ALU_NOR;
          F_SLT:         dec_code = ALU_SLT;
          F_SLTU:        dec_code = ALU_SLTU;
          F_MULT, F_MULTU: begin
            dec_md     = 1'b1;
            dec_hazard = 1'b1;
          end
          F_DIV, F_DIVU: begin
            dec_hazard = 1'b1;
`ifdef ALU_CTRL_DIV_EN
            dec_md     = 1'b1;
`else
            dec_ill    = 1'b1;
`endif
          end
          F_MFHI: begin
            dec_hsel   = HILO_HI;
            dec_hazard = 1'b1;
          end
          F_MFLO: begin
            dec_hsel   = HILO_LO;
            dec_hazard = 1'b1;
          end
          default: dec_ill = 1'b1;
        endcase
      end
    endcase
  end

  // busy_o stays high through the hilo_we_o cycle, so a dependent mfhi/mflo
  // arriving then is held off one more cycle and reads the written value.
  assign stall_o = valid_i & busy_o & dec_hazard;
  assign accept  = valid_i & ~stall_o;
  assign md_go   = accept & dec_md;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_ctl_o   <= S_ALU'(ALU_ADD);
      ctl_valid_o <= 1'b0;
      illegal_o   <= 1'b0;
      hilo_sel_o  <= HILO_NONE;
      md_start_o  <= 1'b0;
    end else begin
      ctl_valid_o <= accept;
      md_start_o  <= md_go;
      if (accept) begin
        alu_ctl_o  <= S_ALU'(dec_code);
        illegal_o  <= dec_ill;
        hilo_sel_o <= dec_hsel;
      end
    end
  end

  // md op encoding is funct[1:0] of the mult/multu/div/divu opcodes.
  md_seq #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (md_go),
    .is_div  (f6[1]),
    .op      (f6[1:0]),
    .md_op   (md_op_o),
    .busy    (busy_o),
    .hilo_we (hilo_we_o),
    .state   (md_state_o)
  );

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Testbench for alu_ctrl_seq: directed scenarios plus randomized traffic
// checked against a cycle-count reference model.
module tb_alu_ctrl_seq;

  localparam int MULT_CYC = 4;
  localparam int DIV_CYC  = 32;
  localparam int EW       = 8;  // {md_start, hilo_sel[1:0], illegal, code[3:0]}

  logic       clk;
  logic       rst_n;
  logic       valid_i;
  logic [5:0] funct_i;
  logic [1:0] alu_op_i;
  logic [3:0] alu_ctl_o;
  logic       ctl_valid_o;
  logic       illegal_o;
  logic [1:0] hilo_sel_o;
  logic       md_start_o;
  logic [1:0] md_op_o;
  logic       busy_o;
  logic       hilo_we_o;
  logic       stall_o;
  logic [0:0] md_state_o;

  alu_ctrl_seq #(
    .SIZEOP      (6),
    .SIZE_ALU_OP (2),
    .S_ALU       (4),
    .MULT_CYCLES (MULT_CYC),
    .DIV_CYCLES  (DIV_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_i     (valid_i),
    .funct_i     (funct_i),
    .alu_op_i    (alu_op_i),
    .alu_ctl_o   (alu_ctl_o),
    .ctl_valid_o (ctl_valid_o),
    .illegal_o   (illegal_o),
    .hilo_sel_o  (hilo_sel_o),
    .md_start_o  (md_start_o),
    .md_op_o     (md_op_o),
    .busy_o      (busy_o),
    .hilo_we_o   (hilo_we_o),
    .stall_o     (stall_o),
    .md_state_o  (md_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  int         rem      = 0;       // busy cycles remaining, including this one
  logic [3:0] hold_code = 4'b0010;
  logic [1:0] exp_md_op = 2'b00;
  logic [EW-1:0] exp_q[$];
  logic [3:0] alu_tbl [logic [5:0]];
  logic [5:0] pick_tbl [16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Decode from the instruction-set table.
  task automatic ref_decode(input logic [1:0] op, input logic [5:0] f,
                            output logic [3:0] code, output logic ill,
                            output logic [1:0] hsel, output logic md,
                            output logic haz);
    code = 4'b0010; ill = 1'b0; hsel = 2'b00; md = 1'b0; haz = 1'b0;
    if (op == 2'b00)      code = 4'b0010;
    else if (op == 2'b01) code = 4'b0110;
    else if (op == 2'b11) code = 4'b0001;
    else if (alu_tbl.exists(f)) code = alu_tbl[f];
    else if (f >= 6'd24 && f <= 6'd27) begin
      haz = 1'b1;
`ifdef ALU_CTRL_DIV_EN
      md = 1'b1;
`else
      if (f <= 6'd25) md = 1'b1;
      else ill = 1'b1;
`endif
    end
    else if (f == 6'd16) begin hsel = 2'b01; haz = 1'b1; end
    else if (f == 6'd18) begin hsel = 2'b10; haz = 1'b1; end
    else ill = 1'b1;
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic v, input logic [1:0] op, input logic [5:0] f,
                      output logic acc);
    logic [3:0] code;
    logic ill, md, haz, exp_stall;
    logic [1:0] hsel;
    logic [EW-1:0] e;
    @(negedge clk);
    valid_i = v; alu_op_i = op; funct_i = f;
    #1;
    ref_decode(op, f, code, ill, hsel, md, haz);
    exp_stall = v && (rem > 0) && haz;
    chk("stall", stall_o, exp_stall);
    chk("busy", busy_o, rem > 0);
    chk("md_state", md_state_o, rem > 0);
    chk("hilo_we", hilo_we_o, rem == 1);
    acc = v && !exp_stall;
    @(posedge clk);
    if (rem > 0) rem--;
    if (acc) begin
      exp_q.push_back({md, hsel, ill, code});
      hold_code = code;
      if (md) begin
        rem = (f >= 6'd26) ? DIV_CYC : MULT_CYC;
        exp_md_op = 2'(f - 6'd24);
      end
    end
    #1;
    chk("ctl_valid", ctl_valid_o, acc);
    chk("alu_ctl", alu_ctl_o, hold_code);
    if (acc) begin
      if (exp_q.size() == 0) begin
        chk("exp_q_empty", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("illegal", illegal_o, e[4]);
        chk("hilo_sel", hilo_sel_o, e[6:5]);
        chk("md_start", md_start_o, e[7]);
      end
    end else begin
      chk("md_start_idle", md_start_o, 0);
    end
    chk("md_op", md_op_o, exp_md_op);
  endtask

  task automatic model_reset();
    rem = 0; hold_code = 4'b0010; exp_md_op = 2'b00;
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_alu_ctl"}, alu_ctl_o, 4'b0010);
    chk({tag, "_ctl_valid"}, ctl_valid_o, 0);
    chk({tag, "_illegal"}, illegal_o, 0);
    chk({tag, "_hilo_sel"}, hilo_sel_o, 2'b00);
    chk({tag, "_md_start"}, md_start_o, 0);
    chk({tag, "_md_op"}, md_op_o, 2'b00);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_hilo_we"}, hilo_we_o, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic acc;
    int   nstall;
    logic [5:0] f;
    logic [1:0] op;

    alu_tbl[6'b100000] = 4'b0010; alu_tbl[6'b100001] = 4'b0010;
    alu_tbl[6'b100010] = 4'b0110; alu_tbl[6'b100011] = 4'b0110;
    alu_tbl[6'b100100] = 4'b0000; alu_tbl[6'b100101] = 4'b0001;
    alu_tbl[6'b100110] = 4'b0011; alu_tbl[6'b100111] = 4'b1100;
    alu_tbl[6'b101010] = 4'b0111; alu_tbl[6'b101011] = 4'b0101;
    pick_tbl = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                 6'h2a, 6'h2b, 6'h18, 6'h19, 6'h1a, 6'h1b, 6'h10, 6'h12};

    valid_i = 1'b0; funct_i = 6'd0; alu_op_i = 2'b00;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    model_reset();

    // directed decode
    step(1, 2'b10, 6'b100000, acc);
    step(1, 2'b10, 6'b101010, acc);
    step(1, 2'b10, 6'b100111, acc);
    step(1, 2'b10, 6'b111111, acc);
    step(0, 2'b10, 6'b000000, acc);
    step(1, 2'b00, 6'b111111, acc);
    step(1, 2'b01, 6'b000000, acc);
    step(1, 2'b11, 6'b100000, acc);

    // mult, independent add while busy, then mflo waits out the op
    step(1, 2'b10, 6'b011000, acc);
    step(1, 2'b10, 6'b100000, acc);
    chk("add_during_busy", acc, 1);
    nstall = 0;
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) begin
      step(1, 2'b10, 6'b010010, acc);
      if (!acc) nstall++;
    end
    chk("mflo_accepted", acc, 1);
    chk("mflo_stall_cycles", nstall, MULT_CYC - 1);
    step(0, 2'b00, 6'b000000, acc);

    // mult immediately followed by mfhi: stalled through the strobe cycle
    step(1, 2'b10, 6'b011001, acc);
    nstall = 0;
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) begin
      step(1, 2'b10, 6'b010000, acc);
      if (!acc) nstall++;
    end
    chk("mfhi_stall_cycles", nstall, MULT_CYC);

    // divu: illegal without the div option, sequenced with it
    step(1, 2'b10, 6'b011011, acc);
    for (int i = 0; i < DIV_CYC + 2; i++) step(0, 2'b00, 6'd0, acc);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      op = (($urandom_range(0, 5)) > 3) ? 2'b10 : 2'($urandom_range(0, 3));
      f  = ($urandom_range(0, 1) == 1) ? pick_tbl[$urandom_range(0, 15)]
                                       : 6'($urandom_range(0, 63));
      step($urandom_range(0, 3) != 0, op, f, acc);
    end
    for (int i = 0; i < DIV_CYC + 2; i++) step(0, 2'b00, 6'd0, acc);

    // reset in the middle of a multi-cycle op
`ifdef ALU_CTRL_DIV_EN
    step(1, 2'b10, 6'b011010, acc);
    for (int i = 0; i < 9; i++) step(0, 2'b00, 6'd0, acc);
`else
    step(1, 2'b10, 6'b011000, acc);
    step(0, 2'b00, 6'd0, acc);
`endif
    chk("busy_before_abort", busy_o, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (2) begin
      @(negedge clk);
      chk("abort_hilo_we", hilo_we_o, 0);
    end
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < DIV_CYC + 2; i++) step(0, 2'b00, 6'd0, acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
